// File: rtl/dual_port_ram_arbiter.sv
// Two-client req/gnt arbiter and issue stage for a 64x8 dual-port RAM.
// Same-address hazards are resolved round-robin; reads return in 2 cycles.
module dual_port_ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_mode_a,
  input  logic [DATA_W-1:0] ram_dout_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  output logic              ram_mode_b,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic              prio_b,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic conflict;
  logic rd_a;
  logic rd_b;

  // Two reads of one address are harmless; anything with a write is not.
  assign conflict = req_a & req_b
                  & (addr_a == addr_b)
                  & (we_a | we_b);

  assign gnt_a = req_a & ~(conflict & prio_b);
  assign gnt_b = req_b & ~(conflict & ~prio_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr_a   <= '0;
      ram_din_a    <= '0;
      ram_mode_a   <= 1'b0;
      ram_addr_b   <= '0;
      ram_din_b    <= '0;
      ram_mode_b   <= 1'b0;
      rd_a         <= 1'b0;
      rd_b         <= 1'b0;
      rvalid_a     <= 1'b0;
      rvalid_b     <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      prio_b       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      ram_mode_a <= gnt_a & we_a;
      ram_mode_b <= gnt_b & we_b;
      if (gnt_a) begin
        ram_addr_a <= addr_a;
        ram_din_a  <= wdata_a;
      end
      if (gnt_b) begin
        ram_addr_b <= addr_b;
        ram_din_b  <= wdata_b;
      end

      // Read issued this cycle is sampled from the async port at the edge.
      rd_a     <= gnt_a & ~we_a;
      rd_b     <= gnt_b & ~we_b;
      rvalid_a <= rd_a;
      rvalid_b <= rd_b;
      if (rd_a) rdata_a <= ram_dout_a;
      if (rd_b) rdata_b <= ram_dout_b;

      if (conflict) begin
        prio_b <= ~prio_b;
        if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level memory model.
module tb_dual_port_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic       ram_mode_a, ram_mode_b;
  logic       prio_b;
  logic [7:0] conflict_cnt;

  dual_port_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_mode_a(ram_mode_a), .ram_dout_a(ram_dout_a),
    .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_mode_b(ram_mode_b), .ram_dout_b(ram_dout_b),
    .prio_b(prio_b), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RAM itself: sync write, async read on each side
  logic       init;
  logic [7:0] mem [64];
  assign ram_dout_a = mem[ram_addr_a];
  assign ram_dout_b = mem[ram_addr_b];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else begin
      if (ram_mode_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_mode_b) mem[ram_addr_b] <= ram_din_b;
    end
  end

  int checks;
  int failures;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as of accepted transactions
  logic [7:0] m_mem [64];
  bit         m_prio;
  int         m_cnt;
  bit         m_mode [2];
  logic [5:0] m_addr [2];
  logic [7:0] m_din  [2];
  bit         m_rv   [2];
  logic [7:0] m_rd   [2];
  bit         p1v    [2];
  logic [7:0] p1d    [2];
  bit         conf, eg_a, eg_b;

  task automatic model_reset();
    m_prio = 0;
    m_cnt  = 0;
    for (int p = 0; p < 2; p++) begin
      m_mode[p] = 0; m_addr[p] = '0; m_din[p] = '0;
      m_rv[p] = 0; m_rd[p] = '0; p1v[p] = 0; p1d[p] = '0;
    end
  endtask

  task automatic check_phase();
    @(negedge clk);
    conf = req_a && req_b && addr_a == addr_b && (we_a || we_b);
    eg_a = req_a && !(conf && m_prio);
    eg_b = req_b && !(conf && !m_prio);
    chk("gnt_a", gnt_a, eg_a);
    chk("gnt_b", gnt_b, eg_b);
    chk("prio_b", prio_b, m_prio);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("rvalid_a", rvalid_a, m_rv[0]);
    chk("rvalid_b", rvalid_b, m_rv[1]);
    chk("rdata_a", rdata_a, m_rd[0]);
    chk("rdata_b", rdata_b, m_rd[1]);
    chk("ram_mode_a", ram_mode_a, m_mode[0]);
    chk("ram_mode_b", ram_mode_b, m_mode[1]);
    chk("ram_addr_a", ram_addr_a, m_addr[0]);
    chk("ram_addr_b", ram_addr_b, m_addr[1]);
    chk("ram_din_a", ram_din_a, m_din[0]);
    chk("ram_din_b", ram_din_b, m_din[1]);
  endtask

  task automatic edge_phase();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      bit         g [2];
      bit         w [2];
      logic [5:0] a [2];
      logic [7:0] d [2];
      g = '{eg_a, eg_b};
      w = '{we_a, we_b};
      a = '{addr_a, addr_b};
      d = '{wdata_a, wdata_b};
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = p1v[p];
        if (p1v[p]) m_rd[p] = p1d[p];
        // Read sees every write accepted in an earlier cycle
        p1v[p] = g[p] && !w[p];
        p1d[p] = m_mem[a[p]];
        m_mode[p] = g[p] && w[p];
        if (g[p]) begin
          m_addr[p] = a[p];
          m_din[p]  = d[p];
        end
      end
      for (int p = 0; p < 2; p++)
        if (g[p] && w[p]) m_mem[a[p]] = d[p];
      if (conf) begin
        m_prio = !eg_b;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
    #1;
  endtask

  task automatic drive(int ra, int wa, int aa, int da,
                       int rb, int wb, int ab, int db);
    req_a = 1'(ra); we_a = 1'(wa); addr_a = 6'(aa); wdata_a = 8'(da);
    req_b = 1'(rb); we_b = 1'(wb); addr_b = 6'(ab); wdata_b = 8'(db);
  endtask

  task automatic step();
    check_phase();
    edge_phase();
  endtask

  typedef struct {
    int ra, wa, aa, da, rb, wb, ab, db;
    int ga, gb, pr, cn, va, rda, vb, rdb;
  } vec_t;

  vec_t tbl [14];

  bit         pa, pb;
  bit         wa, wb;
  logic [5:0] aa, ab;
  logic [7:0] da, db;

  initial begin
    checks = 0;
    failures = 0;
    init = 1'b1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) m_mem[i] = 8'(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;

    // Reset state
    step();
    rst_n = 1'b1;

    //          ra wa aa da     rb wb ab db     ga gb pr cn va rda    vb rdb
    tbl[0]  = '{1, 1, 0, 8'h05, 1, 1, 1, 8'h0A, 1, 1, 0, 0, 0, 0,     0, 0};
    tbl[1]  = '{1, 0, 0, 0,     1, 0, 1, 0,     1, 1, 0, 0, 0, 0,     0, 0};
    tbl[2]  = '{0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 0, 0,     0, 0};
    tbl[3]  = '{0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 0, 1, 8'h05, 1, 8'h0A};
    tbl[4]  = '{1, 1, 5, 8'h11, 1, 1, 5, 8'h22, 1, 0, 0, 0, 0, 8'h05, 0, 8'h0A};
    tbl[5]  = '{0, 0, 0, 0,     1, 1, 5, 8'h22, 0, 1, 1, 1, 0, 8'h05, 0, 8'h0A};
    tbl[6]  = '{1, 0, 5, 0,     0, 0, 0, 0,     1, 0, 1, 1, 0, 8'h05, 0, 8'h0A};
    tbl[7]  = '{1, 1, 5, 8'h11, 1, 1, 5, 8'h22, 0, 1, 1, 1, 0, 8'h05, 0, 8'h0A};
    tbl[8]  = '{1, 1, 5, 8'h11, 0, 0, 0, 0,     1, 0, 0, 2, 1, 8'h22, 0, 8'h0A};
    tbl[9]  = '{1, 0, 5, 0,     1, 1, 9, 8'h3C, 1, 1, 0, 2, 0, 8'h22, 0, 8'h0A};
    tbl[10] = '{1, 0, 9, 0,     1, 0, 9, 0,     1, 1, 0, 2, 0, 8'h22, 0, 8'h0A};
    tbl[11] = '{0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 2, 1, 8'h11, 0, 8'h0A};
    tbl[12] = '{0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 2, 1, 8'h3C, 1, 8'h3C};
    tbl[13] = '{0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 2, 0, 8'h3C, 0, 8'h3C};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da,
            tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      check_phase();
      chk("tbl_gnt_a", gnt_a, tbl[i].ga);
      chk("tbl_gnt_b", gnt_b, tbl[i].gb);
      chk("tbl_prio", prio_b, tbl[i].pr);
      chk("tbl_cnt", conflict_cnt, tbl[i].cn);
      chk("tbl_rvalid_a", rvalid_a, tbl[i].va);
      chk("tbl_rdata_a", rdata_a, tbl[i].rda);
      chk("tbl_rvalid_b", rvalid_b, tbl[i].vb);
      chk("tbl_rdata_b", rdata_b, tbl[i].rdb);
      edge_phase();
    end

    // Saturation of the conflict counter
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1, 1, 7, 8'h01, 1, 1, 7, 8'h02);
    for (int i = 0; i < 300; i++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_phase();
    chk("sat_cnt", conflict_cnt, 255);
    chk("sat_prio", prio_b, 0);
    edge_phase();

    // Reset while a read is in flight
    drive(1, 1, 3, 8'h44, 1, 1, 3, 8'h55);
    step();
    drive(1, 0, 0, 0, 1, 1, 3, 8'h55);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    check_phase();
    chk("rst_cyc_rvalid_a", rvalid_a, 0);
    edge_phase();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_phase();
      chk("rst_rvalid_a", rvalid_a, 0);
      chk("rst_prio", prio_b, 0);
      chk("rst_cnt", conflict_cnt, 0);
      chk("rst_mode_b", ram_mode_b, 0);
      edge_phase();
    end

    // Random traffic; clients hold requests until granted
    pa = 0;
    pb = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; wa = 1'($urandom_range(0, 1));
        aa = 6'($urandom_range(0, 3)); da = 8'($urandom);
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; wb = 1'($urandom_range(0, 1));
        ab = 6'($urandom_range(0, 3)); db = 8'($urandom);
      end
      drive(int'(pa), int'(wa), int'(aa), int'(da),
            int'(pb), int'(wb), int'(ab), int'(db));
      check_phase();
      if (!rst_n) begin
        pa = 0;
        pb = 0;
      end else begin
        if (eg_a) pa = 0;
        if (eg_b) pb = 0;
      end
      edge_phase();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_arbiter.md
Name: dual_port_ram_arbiter

Overview:
Request arbiter and sequencer that sits in front of the 64x8 dual-port RAM. The RAM has one synchronous write port and one asynchronous read port per side. The arbiter accepts one request per cycle on each of two client ports using a req/gnt handshake. It detects same-address hazards between the two ports and resolves them with round-robin priority. It registers the accepted requests onto the RAM port pins and returns read data with fixed latency.

Parameters:
ADDR_W, 6, address width (RAM depth 2**ADDR_W)
DATA_W, 8, data width
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
req_a  input  1  client A request; held with we/addr/wdata stable until granted
we_a  input  1  client A: 1=write, 0=read
addr_a  input  ADDR_W  client A address
wdata_a  input  DATA_W  client A write data
gnt_a  output  1  client A request accepted this cycle (combinational)
rdata_a  output  DATA_W  client A read data
rvalid_a  output  1  rdata_a valid, one-cycle pulse
req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b  same as A for client B
ram_addr_a  output  ADDR_W  to RAM addr_A
ram_din_a  output  DATA_W  to RAM data_in_A
ram_mode_a  output  1  to RAM mode_A (1=write, 0=read)
ram_dout_a  input  DATA_W  from RAM data_out_A (async read)
ram_addr_b, ram_din_b, ram_mode_b, ram_dout_b  same for RAM port B
prio_b  output  1  current round-robin owner (0=A, 1=B)
conflict_cnt  output  CNT_W  number of conflicts resolved, saturating

Behaviour:
- Reset values (rst_n=0 at posedge):
  - all ram_* outputs 0; ram_mode_* 0, so no write is issued
  - rdata_* 0, rvalid_* 0, prio_b 0, conflict_cnt 0
  - any in-flight read is dropped: rvalid stays 0 in the cycle after reset
- Conflict: req_a && req_b && addr_a==addr_b && (we_a || we_b). Two reads of the same address are not a conflict.
- Grant:
  - no conflict: gnt_x = req_x
  - conflict: only the prio_b owner is granted; the loser's gnt is 0 and it keeps req asserted
- Priority and counter update:
  - on every conflict cycle, prio_b toggles to the loser and conflict_cnt increments, saturating at 2**CNT_W-1
  - no conflict: prio_b and conflict_cnt hold
- Issue stage (registered), at the posedge after acceptance:
  - ram_addr_x <= addr_x, ram_din_x <= wdata_x, ram_mode_x <= we_x
  - ungranted port: ram_mode_x <= 0; addr and din hold their previous values
  - a write accepted in cycle N is committed by the RAM at the end of cycle N+1
- Read return:
  - a read accepted in cycle N is driven to the RAM in cycle N+1
  - ram_dout_x is captured into rdata_x at the end of N+1; rvalid_x=1 during cycle N+2 only
  - rdata_x holds its value when rvalid_x is 0
  - latency 2 cycles; throughput 1 request per port per cycle
- Ordering: a lost request is issued strictly after the winner's. For a write/read conflict the read therefore returns the written data if the writer won, and the old data if the reader won.
- Two accepted writes can never target the same address in the same issue cycle.
- Reset mid-operation: prio_b returns to A; a pending ungranted client must re-present its request after reset releases.

Test Plan:
- Disjoint writes: A writes addr 0 = 0x05, B writes addr 1 = 0x0A, same cycle → gnt_a=gnt_b=1; ram_mode_a=ram_mode_b=1 next cycle; later reads return 0x05 and 0x0A with rvalid two cycles after grant.
- Write/write collision: both write addr 5 (A 0x11, B 0x22) from reset → cycle 0 gnt_a=1, gnt_b=0, conflict_cnt=1, prio_b=1; cycle 1 gnt_b=1; read of addr 5 returns 0x22.
- Alternation: repeat the collision immediately → B wins first, final value 0x11, prio_b back to 0, conflict_cnt=2.
- Read/read same address 9 → both granted, no count change, rdata_a=rdata_b=stored value, both rvalid pulse together.
- Saturation: force 300 conflicts → conflict_cnt stops at 255, prio_b still alternates.
- Reset mid-read: read accepted, rst_n=0 next cycle → rvalid_a never pulses; all outputs 0 and prio_b=0 after reset.
